aural_mode_ctrl: RTL and testbench
==================================

# aural_mode_ctrl

Parametrised successor to the two-channel stereo mode controller. Holds an N-channel aural enable mask that steps down (next) or up (previous) through all 2^NUM_CH masks on debounced button edges, or is loaded directly. Each channel has a gain that ramps toward its target (full or mute) one step per sample tick, so mode changes are click-free. Sits between the button debouncers and the per-channel output mixer.

## Interface
- NUM_CH, 2: number of audio channels; mask width.
- GAIN_W, 8: gain width; GAIN_MAX = 2^GAIN_W-1.
- STEP, 64: gain change per sample tick, 1..GAIN_MAX.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_next  in  1  debounced level; rising edge = step mask down.
- btn_prev  in  1  debounced level; rising edge = step mask up.
- mode_load  in  1  direct-load strobe.
- mode_in  in  NUM_CH  mask for mode_load.
- sample_tick  in  1  one-cycle pulse, audio sample rate.
- aural_state  out  NUM_CH  current enable mask; bit i = channel i on.
- gain_out  out  NUM_CH*GAIN_W  channel i gain at [i*GAIN_W +: GAIN_W].
- busy  out  1  high while any gain differs from its target.

## Operation
- Reset (rst low, async): aural_state = all ones, every gain = GAIN_MAX, busy = 0, both edge-detect registers = 1.
- Edge detect: nxt_edge = btn_next & ~prev_next_q; same for prev. Registers reset to 1 so a button held through reset release produces no edge.
- Mode update priority, per cycle:
  - mode_load = 1: aural_state <= mode_in; button edges ignored.
  - nxt_edge & prv_edge both: no change.
  - nxt_edge: aural_state <= aural_state - 1, wrap 0 -> all ones.
  - prv_edge: aural_state <= aural_state + 1, wrap all ones -> 0.
- NUM_CH = 2, next sequence: 11 -> 10 -> 01 -> 00 -> 11 (matches previous generation).
- Target per channel: GAIN_MAX if aural_state[i] else 0.
- Gain ramp on sample_tick: if gain < target, gain <= min(gain+STEP, target); if gain > target, gain <= max(gain-STEP, 0). Arithmetic in GAIN_W+1 bits, saturated; never wraps.
- No sample_tick: gains hold.
- Mode change mid-ramp: ramp retargets from current gain; no reset of gain.
- busy = OR over channels of (gain != target), derived from registered state.

## Timing
- Button: input high at edge k with prev register low -> aural_state new value after edge k; 1-cycle latency from input change. A held button yields exactly one step.
- mode_load at edge k -> aural_state = mode_in after edge k.
- Mode change and sample_tick in same cycle: that tick ramps toward the old target; new target applies from the next tick.
- busy rises the cycle after the mode changes (if target differs); falls after the tick edge that lands all gains on target.
- Full transition needs ceil(GAIN_MAX/STEP) ticks.
- rst low mid-ramp: outputs return to reset values immediately, no clock needed.

## Structure
- Package aural_pkg: default GAIN_W, STEP, GAIN_MAX function/constant, all-ones mask helper.
- Sub-module gain_ramp (one channel: target bit, sample_tick, gain register, at_target flag), instantiated NUM_CH times via generate.
- Top holds edge detectors, mode register, priority mux, busy OR-reduction.

## Test plan
- Reset (NUM_CH=2, GAIN_W=8, STEP=64): aural_state = 2'b11, gain_out = 16'hFFFF, busy = 0; btn_next held high through release -> no step.
- Four btn_next pulses -> aural_state 10, 01, 00, 11, each one cycle after the rising edge; btn_prev from 11 -> 00.
- btn_next and btn_prev rising same cycle -> state unchanged; mode_load=1, mode_in=01 with btn_next edge -> state 01.
- From 11, btn_next -> 10; ticks drive channel 0 gain 255 -> 191 -> 127 -> 63 -> 0, channel 1 stays 255; busy drops after 4th tick.
- Retarget: after two ticks (gain 127) btn_prev -> 11; next ticks 191, 255; busy drops after 2nd tick.
- Tick coincident with mode change uses old target; rst low mid-ramp -> immediately 11 / 16'hFFFF / busy 0.

Source files
------------

// File: rtl/aural_pkg.sv
// Shared defaults and width helpers for the aural mode controller slice.
package aural_pkg;

    localparam int unsigned DEF_GAIN_W = 8;
    localparam int unsigned DEF_STEP   = 64;

    function automatic logic [31:0] ones_mask(input int unsigned n);
        return (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] gain_max(input int unsigned w);
        return ones_mask(w);
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// One channel gain register ramping toward full or mute by STEP per sample tick.
module gain_ramp
    import aural_pkg::*;
#(
    parameter int unsigned GAIN_W = DEF_GAIN_W,
    parameter int unsigned STEP   = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              target_i,
    input  logic              tick_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic              at_target_o
);

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(gain_max(GAIN_W));
    localparam logic [GAIN_W:0]   STEP_X   = (GAIN_W+1)'(STEP);

    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] tgt;
    logic [GAIN_W:0]   sum;

    assign tgt = target_i ? GAIN_MAX : '0;
    assign sum = {1'b0, gain_q} + STEP_X;

    // Target is only ever 0 or GAIN_MAX, so "below target" means ramping up to
    // GAIN_MAX and "above target" means ramping down to 0; both saturate.
    always_comb begin
        gain_d = gain_q;
        if (tick_i && (gain_q != tgt)) begin
            if (target_i) begin
                gain_d = (sum > {1'b0, tgt}) ? tgt : sum[GAIN_W-1:0];
            end else begin
                gain_d = ({1'b0, gain_q} < STEP_X) ? '0 : (gain_q - STEP_X[GAIN_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain_q <= GAIN_MAX;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o      = gain_q;
    assign at_target_o = (gain_q == tgt);

endmodule

// File: rtl/aural_mode_ctrl.sv
// N-channel aural enable mask with button stepping, direct load and click-free gain ramps.
module aural_mode_ctrl
    import aural_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned GAIN_W = DEF_GAIN_W,
    parameter int unsigned STEP   = DEF_STEP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_next,
    input  logic                     btn_prev,
    input  logic                     mode_load,
    input  logic [NUM_CH-1:0]        mode_in,
    input  logic                     sample_tick,
    output logic [NUM_CH-1:0]        aural_state,
    output logic [NUM_CH*GAIN_W-1:0] gain_out,
    output logic                     busy
);

    localparam logic [NUM_CH-1:0] ALL_ONES = NUM_CH'(ones_mask(NUM_CH));

    logic              prev_next_q, prev_prev_q;
    logic              nxt_edge, prv_edge;
    logic [NUM_CH-1:0] state_q, state_d;
    logic [NUM_CH-1:0] at_tgt;

    assign nxt_edge = btn_next & ~prev_next_q;
    assign prv_edge = btn_prev & ~prev_prev_q;

    // Unsigned wrap of +/-1 gives the 0 <-> all-ones rollover directly.
    always_comb begin
        state_d = state_q;
        if (mode_load) begin
            state_d = mode_in;
        end else if (nxt_edge && !prv_edge) begin
            state_d = state_q - NUM_CH'(1);
        end else if (prv_edge && !nxt_edge) begin
            state_d = state_q + NUM_CH'(1);
        end
    end

    // Edge registers reset high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_next_q <= 1'b1;
            prev_prev_q <= 1'b1;
            state_q     <= ALL_ONES;
        end else begin
            prev_next_q <= btn_next;
            prev_prev_q <= btn_prev;
            state_q     <= state_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gain_ramp #(
            .GAIN_W(GAIN_W),
            .STEP  (STEP)
        ) u_ramp (
            .clk        (clk),
            .rst        (rst),
            .target_i   (state_q[i]),
            .tick_i     (sample_tick),
            .gain_o     (gain_out[i*GAIN_W +: GAIN_W]),
            .at_target_o(at_tgt[i])
        );
    end

    assign aural_state = state_q;
    assign busy        = ~&at_tgt;

endmodule

// File: tb/tb_aural_mode_ctrl.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_aural_mode_ctrl;

    localparam int NUM_CH = 2;
    localparam int GAIN_W = 8;
    localparam int STEP   = 64;
    localparam int GMAX   = 255;
    localparam int NM     = 4;

    logic        clk = 1'b0;
    logic        rst, btn_next, btn_prev, mode_load, sample_tick;
    logic [1:0]  mode_in;
    logic [1:0]  aural_state;
    logic [15:0] gain_out;
    logic        busy;

    aural_mode_ctrl #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .mode_load  (mode_load),
        .mode_in    (mode_in),
        .sample_tick(sample_tick),
        .aural_state(aural_state),
        .gain_out   (gain_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] g;
        logic        b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode as an integer in 0..NM-1, gains as plain ints.
    int m_mode;
    int m_gain[NUM_CH];
    bit m_pn, m_pp;

    function automatic int tgt_of(int mode, int ch);
        return ((mode >> ch) & 1) ? GMAX : 0;
    endfunction

    function automatic void model_step(bit r, bit bn, bit bp, bit ld, int mi, bit tk);
        bit ne, pe;
        if (!r) begin
            m_mode = NM - 1;
            for (int i = 0; i < NUM_CH; i++) m_gain[i] = GMAX;
            m_pn = 1'b1;
            m_pp = 1'b1;
            return;
        end
        if (tk) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int t;
                t = tgt_of(m_mode, i);
                if (m_gain[i] < t)      m_gain[i] = (m_gain[i] + STEP > t) ? t : m_gain[i] + STEP;
                else if (m_gain[i] > t) m_gain[i] = (m_gain[i] - STEP < 0) ? 0 : m_gain[i] - STEP;
            end
        end
        ne = bn && !m_pn;
        pe = bp && !m_pp;
        if (ld)            m_mode = mi;
        else if (ne && !pe) m_mode = (m_mode + NM - 1) % NM;
        else if (pe && !ne) m_mode = (m_mode + 1) % NM;
        m_pn = bn;
        m_pp = bp;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st = 2'(m_mode);
        e.b  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            e.g[i*GAIN_W +: GAIN_W] = 8'(m_gain[i]);
            if (m_gain[i] != tgt_of(m_mode, i)) e.b = 1'b1;
        end
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        n_checks += 3;
        if (aural_state === e.st) n_pass++;
        else $display("FAIL %s aural_state got %b exp %b at %0t", tag, aural_state, e.st, $time);
        if (gain_out === e.g) n_pass++;
        else $display("FAIL %s gain_out got %h exp %h at %0t", tag, gain_out, e.g, $time);
        if (busy === e.b) n_pass++;
        else $display("FAIL %s busy got %b exp %b at %0t", tag, busy, e.b, $time);
    endtask

    task automatic cycle(input bit r, input bit bn, input bit bp, input bit ld,
                         input logic [1:0] mi, input bit tk);
        @(negedge clk);
        rst = r; btn_next = bn; btn_prev = bp; mode_load = ld; mode_in = mi; sample_tick = tk;
        model_step(r, bn, bp, ld, int'(mi), tk);
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 2'b00, 1);
    endtask

    task automatic pulse_next();
        cycle(1, 1, 0, 0, 2'b00, 0);
        cycle(1, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic pulse_prev();
        cycle(1, 0, 1, 0, 2'b00, 0);
        cycle(1, 0, 0, 0, 2'b00, 0);
    endtask

    // Reset asserted between edges; outputs must settle with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        btn_next = 0; btn_prev = 0; mode_load = 0; sample_tick = 0;
        #2 rst = 1'b0;
        model_step(0, 0, 0, 0, 0, 0);
        sb.push_back(model_out());
        #1 compare("async_rst", model_out());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare("mon", e);
            end
        end
    end

    initial begin : driver
        rst = 1'b0; btn_next = 1'b1; btn_prev = 1'b0; mode_load = 1'b0;
        mode_in = 2'b00; sample_tick = 1'b0;
        model_step(0, 0, 0, 0, 0, 0);

        // Reset with btn_next held through release: no step.
        cycle(0, 1, 0, 0, 2'b00, 0);
        cycle(0, 1, 0, 0, 2'b00, 0);
        cycle(1, 1, 0, 0, 2'b00, 0);
        cycle(1, 1, 0, 0, 2'b00, 0);
        idle(1);

        // Next sequence 11 -> 10 -> 01 -> 00 -> 11, then prev 11 -> 00.
        repeat (4) pulse_next();
        pulse_prev();

        // Simultaneous edges, then load beating a button edge.
        cycle(1, 1, 1, 0, 2'b00, 0);
        idle(1);
        cycle(1, 1, 0, 1, 2'b01, 0);
        idle(1);

        // Load 11, settle, then ramp channel 0 down to mute.
        cycle(1, 0, 0, 1, 2'b11, 0);
        ticks(5);
        pulse_next();
        ticks(5);

        // Retarget mid-ramp.
        cycle(1, 0, 0, 1, 2'b11, 0);
        ticks(5);
        pulse_next();
        ticks(2);
        pulse_prev();
        ticks(3);

        // Tick coincident with the mode change uses the old target.
        cycle(1, 1, 0, 0, 2'b00, 1);
        ticks(2);

        // Async reset mid-ramp, then recover.
        async_reset();
        cycle(0, 0, 0, 0, 2'b00, 0);
        idle(2);

        // Randomised phase.
        for (int i = 0; i < 600; i++) begin
            bit r, bn, bp, ld, tk;
            r  = ($urandom_range(0, 79) != 0);
            bn = ($urandom_range(0, 3) == 0);
            bp = ($urandom_range(0, 3) == 0);
            ld = ($urandom_range(0, 11) == 0);
            tk = ($urandom_range(0, 2) == 0);
            cycle(r, bn, bp, ld, 2'($urandom_range(0, 3)), tk);
        end
        idle(1);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain scoreboard entries left %0d exp 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
